// File: rtl/seq_pattern_detector_if.sv
// Bundles the stream, control and status signals of seq_pattern_detector.
//   master : drives load/pat_in/len_in/mode_ovl/en/clr_cnt/inp and
//            observes out/armed/match_cnt
//   slave  : the detector side
interface seq_pattern_detector_if #(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = $clog2(PAT_LEN + 1);

    logic               load;
    logic [PAT_LEN-1:0] pat_in;
    logic [LEN_W-1:0]   len_in;
    logic               mode_ovl;
    logic               en;
    logic               clr_cnt;
    logic               inp;
    logic               out;
    logic               armed;
    logic [CNT_W-1:0]   match_cnt;

    modport master (
        output load, pat_in, len_in, mode_ovl, en, clr_cnt, inp,
        input  out, armed, match_cnt
    );

    modport slave (
        input  load, pat_in, len_in, mode_ovl, en, clr_cnt, inp,
        output out, armed, match_cnt
    );
endinterface

// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector. Watches the MSB-first stream bus.inp for a
// runtime-programmable pattern of 1..PAT_LEN bits and emits a registered
// one-cycle pulse per match, with overlapping or non-overlapping detection,
// a bit-valid qualifier and a saturating match counter.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : seq_pattern_detector_if.slave (load/pat_in/len_in/mode_ovl/en/
//          clr_cnt/inp in; out/armed/match_cnt out)
module seq_pattern_detector #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] DEF_PAT = 4'b1011,
    parameter int                 DEF_LEN = 4,
    parameter int                 CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    seq_pattern_detector_if.slave   bus
);
    localparam int                 LEN_W = $clog2(PAT_LEN + 1);
    localparam logic [LEN_W-1:0]   MAXLEN = LEN_W'(PAT_LEN);
    localparam logic [PAT_LEN-1:0] ONES   = {PAT_LEN{1'b1}};

    typedef enum logic {FILL, HUNT} state_t;

    state_t             state_q, state_d;
    logic [PAT_LEN-1:0] pat_q, pat_d;
    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               out_q, out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [LEN_W-1:0]   fill_inc;
    logic [PAT_LEN-1:0] shifted;
    logic [PAT_LEN-1:0] mask;
    logic               hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            pat_q   <= DEF_PAT;
            len_q   <= LEN_W'(DEF_LEN);
            hist_q  <= '0;
            fill_q  <= '0;
            out_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        fill_inc = (fill_q >= MAXLEN) ? fill_q : fill_q + 1'b1;
        shifted  = {hist_q[PAT_LEN-2:0], bus.inp};
        // Only the low len bits take part in the compare.
        mask     = ~(ONES << len_q);
        hit      = bus.en && !bus.load && (fill_inc >= len_q) &&
                   ((shifted & mask) == (pat_q & mask));

        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        out_d   = 1'b0;
        cnt_d   = cnt_q;

        if (bus.load) begin
            // Restart from scratch; the inp bit on this edge is dropped.
            pat_d   = bus.pat_in;
            len_d   = (bus.len_in == '0 || bus.len_in > MAXLEN) ? MAXLEN : bus.len_in;
            hist_d  = '0;
            fill_d  = '0;
            state_d = FILL;
        end else if (bus.en) begin
            hist_d = shifted;
            fill_d = fill_inc;
            case (state_q)
                FILL:    if (fill_inc >= len_q) state_d = HUNT;
                HUNT:    state_d = HUNT;
                default: state_d = FILL;
            endcase
            if (hit) begin
                out_d = 1'b1;
                if (!bus.mode_ovl) begin
                    // Non-overlapping: the matched bits may not seed the next match.
                    hist_d  = '0;
                    fill_d  = '0;
                    state_d = FILL;
                end
            end
        end

        if (bus.clr_cnt)
            cnt_d = '0;
        else if (hit && cnt_q != '1)
            cnt_d = cnt_q + 1'b1;
    end

    assign bus.out       = out_q;
    assign bus.armed     = (state_q == HUNT);
    assign bus.match_cnt = cnt_q;
endmodule
